// File: rtl/ts_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ts_pkg
// Description : Shared MPEG2-TS constants and the packet-sync state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ts_pkg;

  localparam int                  TS_PKT_LEN   = 188;
  localparam logic [7:0]          TS_SYNC_BYTE = 8'h47;
  localparam int                  TS_PID_W     = 13;

  // Reserved PIDs, exported for the downstream QoS logic.
  localparam logic [TS_PID_W-1:0] NULL_PID     = 13'h1FFF;
  localparam logic [TS_PID_W-1:0] PAT_PID      = 13'h0000;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } ts_state_e;

endpackage : ts_pkg
`default_nettype wire

// File: rtl/ts_packet_sync.sv
`default_nettype none
// ============================================================================
// Module      : ts_packet_sync
// Description : Hunts for the TS sync byte at PKT_LEN spacing in an unaligned
//               byte stream, locks after LOCK_COUNT consecutive syncs and then
//               forwards packet-aligned bytes with sop/eop, extracting PID/TEI.
// Ports       : rclk/rrst     - clock, synchronous active-high reset
//               data_in       - stream byte, qualified by valid_in
//               data_out      - aligned byte, qualified by valid_out
//               sop/eop       - first/last byte of a packet (with valid_out)
//               pid/tei       - header fields, updated with pid_valid pulse
//               locked        - high while aligned
//               sync_loss     - one-cycle pulse when lock is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module ts_packet_sync
  import ts_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    PKT_LEN    = TS_PKT_LEN,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = TS_SYNC_BYTE,
  parameter int                    LOCK_COUNT = 3,   // must be >= 2
  parameter int                    LOSS_COUNT = 3
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  sop,
  output logic                  eop,
  output logic [TS_PID_W-1:0]   pid,
  output logic                  tei,
  output logic                  pid_valid,
  output logic                  locked,
  output logic                  sync_loss
);

  localparam int IDX_W  = $clog2(PKT_LEN);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PKT_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_TWO   = IDX_W'(2);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_COUNT);

  ts_state_e           state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d, idx_inc;
  logic [GOOD_W-1:0]   good_q, good_d, good_inc;
  logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
  logic                tei_hdr_q, tei_hdr_d;
  logic [4:0]          pid_hi_q, pid_hi_d;

  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_d, sop_d, eop_d, pid_valid_d, sync_loss_d, tei_d;
  logic [TS_PID_W-1:0]   pid_d;
  logic                  is_sync;

  assign is_sync  = (data_in == SYNC_BYTE);
  assign idx_inc  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
  assign good_inc = good_q + GOOD_W'(1);
  assign miss_inc = miss_q + MISS_W'(1);

  // Next-state, counters and output values; registered below so every
  // output appears one cycle after the byte that caused it.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    good_d      = good_q;
    miss_d      = miss_q;
    tei_hdr_d   = tei_hdr_q;
    pid_hi_d    = pid_hi_q;
    data_d      = data_out;   // hold last byte when nothing is forwarded
    valid_d     = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    pid_d       = pid;
    tei_d       = tei;
    pid_valid_d = 1'b0;
    sync_loss_d = 1'b0;

    case (state_q)
      HUNT: begin
        if (valid_in && is_sync) begin
          state_d = VERIFY;
          idx_d   = IDX_ONE;
          good_d  = GOOD_W'(1);
        end
      end

      VERIFY: begin
        if (valid_in) begin
          if (idx_q == '0) begin
            if (is_sync) begin
              idx_d  = IDX_ONE;
              good_d = good_inc;
              if (good_inc == GOOD_LOCK) begin
                // The confirming sync byte is the first forwarded byte.
                state_d = LOCKED;
                good_d  = '0;
                miss_d  = '0;
                valid_d = 1'b1;
                data_d  = data_in;
                sop_d   = 1'b1;
              end
            end else begin
              // Mismatched byte is discarded, not reconsidered as a sync.
              state_d = HUNT;
              idx_d   = '0;
              good_d  = '0;
            end
          end else begin
            idx_d = idx_inc;
          end
        end
      end

      LOCKED: begin
        if (valid_in) begin
          idx_d = idx_inc;
          if ((idx_q == '0) && !is_sync && (miss_inc == MISS_LOSS)) begin
            state_d     = HUNT;
            idx_d       = '0;
            miss_d      = '0;
            sync_loss_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            data_d  = data_in;
            sop_d   = (idx_q == '0);
            eop_d   = (idx_q == IDX_LAST);
            if (idx_q == '0) begin
              miss_d = is_sync ? '0 : miss_inc;
            end
            if (idx_q == IDX_ONE) begin
              tei_hdr_d = data_in[7];
              pid_hi_d  = data_in[4:0];
            end
            if (idx_q == IDX_TWO) begin
              pid_d       = {pid_hi_q, data_in};
              tei_d       = tei_hdr_q;
              pid_valid_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = HUNT;
        idx_d   = '0;
        good_d  = '0;
        miss_d  = '0;
      end
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q   <= HUNT;
      idx_q     <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      tei_hdr_q <= 1'b0;
      pid_hi_q  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      pid       <= '0;
      tei       <= 1'b0;
      pid_valid <= 1'b0;
      locked    <= 1'b0;
      sync_loss <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      tei_hdr_q <= tei_hdr_d;
      pid_hi_q  <= pid_hi_d;
      data_out  <= data_d;
      valid_out <= valid_d;
      sop       <= sop_d;
      eop       <= eop_d;
      pid       <= pid_d;
      tei       <= tei_d;
      pid_valid <= pid_valid_d;
      locked    <= (state_d == LOCKED);
      sync_loss <= sync_loss_d;
    end
  end

endmodule : ts_packet_sync
`default_nettype wire

// File: tb/tb_ts_packet_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_ts_packet_sync
// Description : Directed bench for ts_packet_sync: clean lock, loss, false
//               sync, single-corruption recovery, gapped input and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ts_packet_sync;
  import ts_pkg::*;

  logic        rclk = 1'b0;
  logic        rrst;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [7:0]  data_out;
  logic        valid_out, sop, eop, tei, pid_valid, locked, sync_loss;
  logic [12:0] pid;

  ts_packet_sync dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .sop       (sop),
    .eop       (eop),
    .pid       (pid),
    .tei       (tei),
    .pid_valid (pid_valid),
    .locked    (locked),
    .sync_loss (sync_loss)
  );

  always #5 rclk = ~rclk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int gap = 0;
  int cur_pkt = -1;
  int epoch = 0;

  // Event counters, written only by the monitor.
  int n_vo = 0, n_sop = 0, n_eop = 0, n_pv = 0, n_loss = 0, n_bad = 0;
  int sop_epoch = 0, first_sop_pkt = -1;
  int s_vo, s_sop, s_eop, s_pv, s_loss;

  always @(posedge rclk) begin
    #1;
    if (valid_out) begin
      n_vo++;
      if (!locked) n_bad++;
    end
    if (valid_out && sop) begin
      n_sop++;
      if (sop_epoch != epoch) begin
        sop_epoch     = epoch;
        first_sop_pkt = cur_pkt;
      end
    end
    if (valid_out && eop) n_eop++;
    if (pid_valid) n_pv++;
    if (sync_loss) begin
      n_loss++;
      if (locked) n_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data_out"},  32'(data_out),  32'h0);
    chk({tag, "_valid_out"}, 32'(valid_out), 32'h0);
    chk({tag, "_sop"},       32'(sop),       32'h0);
    chk({tag, "_eop"},       32'(eop),       32'h0);
    chk({tag, "_pid"},       32'(pid),       32'h0);
    chk({tag, "_tei"},       32'(tei),       32'h0);
    chk({tag, "_pid_valid"}, 32'(pid_valid), 32'h0);
    chk({tag, "_locked"},    32'(locked),    32'h0);
    chk({tag, "_sync_loss"}, 32'(sync_loss), 32'h0);
  endtask

  task automatic snap();
    s_vo = n_vo; s_sop = n_sop; s_eop = n_eop; s_pv = n_pv; s_loss = n_loss;
  endtask

  task automatic send(input logic [7:0] b, input int id);
    @(negedge rclk);
    data_in  = b;
    valid_in = 1'b1;
    cur_pkt  = id;
    repeat (gap) begin
      @(negedge rclk);
      valid_in = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge rclk);
      valid_in = 1'b0;
    end
  endtask

  task automatic send_pkt(input int id, input logic [7:0] s, input logic [7:0] b1,
                          input logic [7:0] b2);
    send(s, id);
    send(b1, id);
    send(b2, id);
    for (int i = 3; i < 188; i++) send(8'(i & 63), id);  // payload never 0x47
  endtask

  task automatic do_reset(input string tag);
    @(negedge rclk);
    rrst     = 1'b1;
    valid_in = 1'b0;
    @(negedge rclk);
    check_zero(tag);
    rrst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst     = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge rclk);
    check_zero("reset");
    rrst = 1'b0;

    // Clean stream: lock on the third sync, packets 2..4 forwarded.
    snap();
    epoch = 1;
    for (int p = 0; p < 5; p++) send_pkt(p, 8'h47, 8'h41, 8'h00);
    idle(2);
    chk("clean_first_sop_pkt", 32'(first_sop_pkt), 32'd2);
    chk("clean_sop_cnt",  32'(n_sop - s_sop), 32'd3);
    chk("clean_eop_cnt",  32'(n_eop - s_eop), 32'd3);
    chk("clean_pv_cnt",   32'(n_pv - s_pv),   32'd3);
    chk("clean_vo_cnt",   32'(n_vo - s_vo),   32'd564);
    chk("clean_locked",   32'(locked),        32'h1);
    chk("clean_pid",      32'(pid),           32'h0100);
    chk("clean_tei",      32'(tei),           32'h0);

    // Loss: three corrupted syncs; first two forwarded, third drops lock.
    snap();
    for (int p = 5; p < 8; p++) send_pkt(p, 8'h00, 8'h41, 8'h00);
    idle(2);
    chk("loss_sop_cnt",   32'(n_sop - s_sop),   32'd2);
    chk("loss_eop_cnt",   32'(n_eop - s_eop),   32'd2);
    chk("loss_vo_cnt",    32'(n_vo - s_vo),     32'd376);
    chk("loss_pulse_cnt", 32'(n_loss - s_loss), 32'd1);
    chk("loss_locked",    32'(locked),          32'h0);
    snap();
    for (int p = 8; p < 10; p++) send_pkt(p, 8'h47, 8'h41, 8'h00);
    idle(2);
    chk("loss_no_vo_after", 32'(n_vo - s_vo), 32'd0);
    chk("loss_data_hold",   32'(data_out),    32'h3B);

    // Misaligned start with a false sync at garbage offset 10.
    do_reset("reset2");
    snap();
    epoch = 2;
    for (int i = 0; i < 57; i++) send((i == 10) ? 8'h47 : 8'((i * 5 + 1) & 63), 100);
    for (int p = 10; p < 15; p++) send_pkt(p, 8'h47, 8'h41, 8'h00);
    idle(2);
    chk("false_first_sop_pkt", 32'(first_sop_pkt), 32'd13);
    chk("false_sop_cnt",  32'(n_sop - s_sop), 32'd2);
    chk("false_vo_cnt",   32'(n_vo - s_vo),   32'd376);
    chk("false_locked",   32'(locked),        32'h1);

    // Single corruption with TEI/null-PID header, then miss must clear.
    snap();
    send_pkt(20, 8'h00, 8'h9F, 8'hFF);
    idle(2);
    chk("rec_locked1",  32'(locked), 32'h1);
    chk("rec_pid_null", 32'(pid),    32'h1FFF);
    chk("rec_tei",      32'(tei),    32'h1);
    send_pkt(21, 8'h47, 8'h41, 8'h00);
    send_pkt(22, 8'h00, 8'h41, 8'h00);
    send_pkt(23, 8'h00, 8'h41, 8'h00);
    send_pkt(24, 8'h47, 8'h41, 8'h00);
    idle(2);
    chk("rec_locked2",  32'(locked),          32'h1);
    chk("rec_no_loss",  32'(n_loss - s_loss), 32'd0);
    chk("rec_sop_cnt",  32'(n_sop - s_sop),   32'd5);
    chk("rec_pv_cnt",   32'(n_pv - s_pv),     32'd5);
    chk("rec_pid",      32'(pid),             32'h0100);
    chk("rec_tei_clr",  32'(tei),             32'h0);

    // Gapped input, 1 valid in 4 cycles: same result as the clean stream.
    do_reset("reset3");
    snap();
    epoch = 3;
    gap   = 3;
    for (int p = 30; p < 35; p++) send_pkt(p, 8'h47, 8'h41, 8'h00);
    idle(2);
    chk("gap_first_sop_pkt", 32'(first_sop_pkt), 32'd32);
    chk("gap_sop_cnt", 32'(n_sop - s_sop), 32'd3);
    chk("gap_eop_cnt", 32'(n_eop - s_eop), 32'd3);
    chk("gap_pv_cnt",  32'(n_pv - s_pv),   32'd3);
    chk("gap_vo_cnt",  32'(n_vo - s_vo),   32'd564);
    chk("gap_locked",  32'(locked),        32'h1);
    chk("gap_pid",     32'(pid),           32'h0100);

    // Reset mid-packet with a simultaneous valid sync byte (dropped).
    send(8'h47, 35);
    for (int i = 1; i < 100; i++) send(8'(i & 63), 35);
    gap = 0;
    @(negedge rclk);
    rrst     = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h47;
    @(negedge rclk);
    check_zero("mid_reset");
    rrst     = 1'b0;
    valid_in = 1'b0;

    snap();
    epoch = 4;
    send_pkt(40, 8'h47, 8'h41, 8'h00);
    send_pkt(41, 8'h47, 8'h41, 8'h00);
    idle(2);
    chk("relock_sop_early", 32'(n_sop - s_sop), 32'd0);
    chk("relock_locked0",   32'(locked),        32'h0);
    send_pkt(42, 8'h47, 8'h41, 8'h00);
    idle(2);
    chk("relock_sop_cnt",   32'(n_sop - s_sop), 32'd1);
    chk("relock_first_sop", 32'(first_sop_pkt), 32'd42);
    chk("relock_locked1",   32'(locked),        32'h1);

    chk("never_vo_unlocked", 32'(n_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_ts_packet_sync
`default_nettype wire
